// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DELAY    = 2'd1,
        SELECTED = 2'd2,
        SHIFT    = 2'd3
    } state_t;

    localparam int DEFAULT_DELAY_CYCLES = 200;

endpackage

// File: rtl/spi_shifter.sv
// Mode-0 byte shifter: 8-bit shift registers, bit counter and sck generation.
import spi_pkg::*;

module spi_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       sdi,
    output logic       sck,
    output logic       mosi,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       done
);

    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic [2:0] bit_cnt;
    logic       active;

    // The edge that lowers sck for the eighth time closes the byte.
    assign done = active && sck && (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            active   <= 1'b0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (load) begin
                tx_sr   <= din;
                mosi    <= din[7];
                sck     <= 1'b0;
                bit_cnt <= '0;
                active  <= 1'b1;
            end else if (active) begin
                sck <= ~sck;
                if (!sck) begin
                    rx_sr <= {rx_sr[6:0], sdi};
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                    tx_sr   <= {tx_sr[6:0], 1'b0};
                    mosi    <= tx_sr[6];
                    if (bit_cnt == 3'd7) begin
                        active   <= 1'b0;
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sr;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi.sv
// SPI master with chip-select setup delay; define SPI_LOOPBACK_EN
// to feed mosi back into the receive shifter instead of miso.
import spi_pkg::*;

module spi #(
    parameter int DELAY_CYCLES = DEFAULT_DELAY_CYCLES,
    parameter int CNT_W        = 8
) (
    input  logic       clk_800k,
    input  logic       rst_n,
    input  logic       begin_transaction,
    input  logic       end_transaction,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       cs
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] delay_count;
    logic             delay_finished;
    logic             end_pending;
    logic             handshake;
    logic             byte_done;
    logic             sdi;

    assign tx_ready  = (state == SELECTED);
    assign cs        = (state == IDLE);
    assign handshake = tx_valid && tx_ready;

`ifdef SPI_LOOPBACK_EN
    assign sdi = mosi;
`else
    assign sdi = miso;
`endif

    always_ff @(posedge clk_800k or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // A handshake wins over a same-cycle close; the close is then latched.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (begin_transaction) next_state = DELAY;
            DELAY: begin
                if (end_transaction)          next_state = IDLE;
                else if (delay_count == LAST) next_state = SELECTED;
            end
            SELECTED: begin
                if (handshake)            next_state = SHIFT;
                else if (end_transaction) next_state = IDLE;
            end
            SHIFT: begin
                if (byte_done)
                    next_state = (end_pending || end_transaction)
                               ? IDLE : SELECTED;
            end
        endcase
    end

    always_ff @(posedge clk_800k or negedge rst_n) begin
        if (!rst_n) begin
            delay_count    <= '0;
            delay_finished <= 1'b0;
            end_pending    <= 1'b0;
        end else begin
            if (state == IDLE && begin_transaction) begin
                delay_count    <= '0;
                delay_finished <= 1'b0;
            end else if (state == DELAY) begin
                delay_count <= delay_count + CNT_W'(1);
                if (next_state == SELECTED) delay_finished <= 1'b1;
            end
            if (state == IDLE || byte_done)
                end_pending <= 1'b0;
            else if (end_transaction && (state == SHIFT || handshake))
                end_pending <= 1'b1;
        end
    end

    spi_shifter u_shifter (
        .clk      (clk_800k),
        .rst_n    (rst_n),
        .load     (handshake),
        .din      (tx_data),
        .sdi      (sdi),
        .sck      (sck),
        .mosi     (mosi),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .done     (byte_done)
    );

endmodule

// File: tb/tb_spi.sv
// Self-checking bench for spi: scenario tasks against a simple
// cycle-count / byte-level reference model.
module tb_spi;

    localparam int DLY = 200;

    logic       clk_800k = 1'b0;
    logic       rst_n = 1'b0;
    logic       begin_transaction = 1'b0;
    logic       end_transaction = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       sck;
    logic       mosi;
    logic       miso = 1'b0;
    logic       cs;

    int compared = 0;
    int mismatched = 0;

    spi #(.DELAY_CYCLES(DLY), .CNT_W(8)) dut (
        .clk_800k          (clk_800k),
        .rst_n             (rst_n),
        .begin_transaction (begin_transaction),
        .end_transaction   (end_transaction),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .sck               (sck),
        .mosi              (mosi),
        .miso              (miso),
        .cs                (cs)
    );

    always #5 clk_800k = ~clk_800k;

    task automatic tick();
        @(posedge clk_800k);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        compared++;
        if ({dut.state, cs, sck, mosi, dut.delay_count, dut.delay_finished,
             rx_data, rx_valid, tx_ready} !== {2'd0, 1'b1, 1'b0, 1'b0, 8'd0,
             1'b0, 8'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: st=%0d cs=%b sck=%b mosi=%b cnt=%0d fin=%b rx=%h rv=%b rdy=%b",
                     dut.state, cs, sck, mosi, dut.delay_count,
                     dut.delay_finished, rx_data, rx_valid, tx_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle();
        repeat (10) tick();
        compared++;
        if (cs !== 1'b1 || dut.state !== 2'd0) begin
            mismatched++;
            $display("FAIL idle: cs=%b state=%0d, want cs=1 state=0",
                     cs, dut.state);
        end
    endtask

    task automatic test_start();
        begin_transaction = 1'b1;
        tick();
        for (int k = 0; k <= 350; k++) begin
            if (k == 50 || k == 100) begin
                compared++;
                if (cs !== 1'b0 || dut.state !== 2'd1 ||
                    dut.delay_finished !== 1'b0 ||
                    dut.delay_count !== 8'(k)) begin
                    mismatched++;
                    $display("FAIL start_%0d: cs=%b st=%0d fin=%b cnt=%0d",
                             k, cs, dut.state, dut.delay_finished,
                             dut.delay_count);
                end
            end
            if (k == 350) begin
                compared++;
                if (dut.delay_finished !== 1'b1 || dut.state !== 2'd2) begin
                    mismatched++;
                    $display("FAIL start_350: fin=%b st=%0d, want 1/2",
                             dut.delay_finished, dut.state);
                end
            end
            if (k < 350) tick();
        end
        begin_transaction = 1'b0;
        repeat (250) tick();
        compared++;
        if (dut.state !== 2'd2 || cs !== 1'b0 || sck !== 1'b0 ||
            tx_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL release: st=%0d cs=%b sck=%b rdy=%b",
                     dut.state, cs, sck, tx_ready);
        end
    endtask

    // Sends one byte from SELECTED; end_at = half-cycle index to close, or -1.
    task automatic run_byte(input logic [7:0] tx, input logic [7:0] src,
                            input int end_at);
        logic [1:0] want_st;
        tx_data  = tx;
        tx_valid = 1'b1;
        miso     = src[7];
        tick();
        tx_valid = 1'b0;
        compared++;
        if (dut.state !== 2'd3 || tx_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL load: st=%0d rdy=%b, want 3/0", dut.state, tx_ready);
        end
        for (int h = 0; h < 16; h++) begin
            int b = h / 2;
            if (h % 2 == 0) miso = src[7-b];
            if (h == end_at) end_transaction = 1'b1;
            tick();
            end_transaction = 1'b0;
            if (h % 2 == 0) begin
                compared++;
                if (sck !== 1'b1 || mosi !== tx[7-b]) begin
                    mismatched++;
                    $display("FAIL rise_%0d: sck=%b mosi=%b, want 1/%b",
                             b, sck, mosi, tx[7-b]);
                end
            end else if (h < 15) begin
                compared++;
                if (sck !== 1'b0 || rx_valid !== 1'b0 || cs !== 1'b0) begin
                    mismatched++;
                    $display("FAIL fall_%0d: sck=%b rv=%b cs=%b, want 0/0/0",
                             b, sck, rx_valid, cs);
                end
            end
        end
        want_st = (end_at >= 0) ? 2'd0 : 2'd2;
        compared++;
        if (rx_valid !== 1'b1 || rx_data !== src || sck !== 1'b0 ||
            dut.state !== want_st || cs !== (end_at >= 0)) begin
            mismatched++;
            $display("FAIL done: rv=%b rx=%h sck=%b st=%0d cs=%b, want 1/%h/0/%0d/%b",
                     rx_valid, rx_data, sck, dut.state, cs, src, want_st,
                     end_at >= 0);
        end
    endtask

    task automatic open_txn();
        begin_transaction = 1'b1;
        tick();
        begin_transaction = 1'b0;
        repeat (DLY) tick();
        compared++;
        if (dut.state !== 2'd2 || dut.delay_finished !== 1'b1) begin
            mismatched++;
            $display("FAIL open: st=%0d fin=%b, want 2/1",
                     dut.state, dut.delay_finished);
        end
    endtask

    task automatic test_byte();
        run_byte(8'h74, 8'hA5, -1);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            logic [7:0] t = 8'($urandom);
            logic [7:0] r = 8'($urandom);
            run_byte(t, r, -1);
        end
        tick();
        compared++;
        if (rx_valid !== 1'b0 || dut.state !== 2'd2) begin
            mismatched++;
            $display("FAIL rv_pulse: rv=%b st=%0d, want 0/2",
                     rx_valid, dut.state);
        end
    endtask

    task automatic test_end_shift();
        logic [7:0] t = 8'($urandom);
        logic [7:0] r = 8'($urandom);
        run_byte(t, r, int'($urandom_range(0, 14)));
    endtask

    task automatic test_end_selected();
        open_txn();
        end_transaction = 1'b1;
        tick();
        end_transaction = 1'b0;
        compared++;
        if (dut.state !== 2'd0 || cs !== 1'b1) begin
            mismatched++;
            $display("FAIL end_selected: st=%0d cs=%b, want 0/1",
                     dut.state, cs);
        end
    endtask

    task automatic test_abort_delay();
        begin_transaction = 1'b1;
        end_transaction   = 1'b1;
        tick();
        begin_transaction = 1'b0;
        end_transaction   = 1'b0;
        repeat (20) tick();
        end_transaction = 1'b1;
        tick();
        end_transaction = 1'b0;
        compared++;
        if (dut.state !== 2'd0 || cs !== 1'b1 ||
            dut.delay_finished !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_delay: st=%0d cs=%b fin=%b, want 0/1/0",
                     dut.state, cs, dut.delay_finished);
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        open_txn();
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        compared++;
        if (cs !== 1'b1 || sck !== 1'b0 || dut.state !== 2'd0 ||
            rx_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid: cs=%b sck=%b st=%0d rv=%b",
                     cs, sck, dut.state, rx_valid);
        end
        repeat (4) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_valid === 1'b1) seen = 1'b1;
        end
        compared++;
        if (seen !== 1'b0 || dut.state !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_after: rv_seen=%b st=%0d, want 0/0",
                     seen, dut.state);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_start();
        test_byte();
        test_back_to_back();
        test_end_shift();
        test_end_selected();
        test_abort_delay();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi.md
SPI -- requirements
Module: spi

Interface
REQ-001 Parameter DELAY_CYCLES, default 200: number of clk_800k cycles chip-select is held low before the first byte may be shifted.
REQ-002 Parameter CNT_W, default 8: width of delay_count; SHALL satisfy 2^CNT_W > DELAY_CYCLES.
REQ-003 clk_800k  input  1  the only clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 begin_transaction  input  1  level request to start a transaction; sampled only in IDLE.
REQ-006 end_transaction  input  1  single-cycle pulse that closes the transaction.
REQ-007 tx_data  input  8  byte to transmit, captured when tx_valid && tx_ready.
REQ-008 tx_valid  input  1  byte request qualifier.
REQ-009 tx_ready  output  1  high only in SELECTED; the byte handshake completes when tx_valid and tx_ready are both high.
REQ-010 rx_data  output  8  last received byte, held until the next byte completes.
REQ-011 rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-012 sck  output  1  SPI clock, mode 0, idle low.
REQ-013 mosi  output  1  serial data out, MSB first.
REQ-014 miso  input  1  serial data in, MSB first.
REQ-015 cs  output  1  active-low chip select.

Function
REQ-016 The internal signals state[1:0], delay_count[CNT_W-1:0] and delay_finished SHALL exist under exactly these names for hierarchical probing.
REQ-017 The state encodings SHALL be IDLE=0, DELAY=1, SELECTED=2, SHIFT=3.
REQ-018 In IDLE with begin_transaction=1, the next edge SHALL set state=DELAY, cs=0, delay_count=0 and delay_finished=0.
REQ-019 In DELAY, delay_count SHALL increment every cycle.
REQ-020 When delay_count reaches DELAY_CYCLES-1, delay_finished SHALL be set and state SHALL become SELECTED on the same edge.
REQ-021 delay_finished SHALL stay high until the next entry to DELAY or reset.
REQ-022 After DELAY is entered, delay_finished SHALL be 0 at 50 and 100 cycles and 1 at 350 cycles.
REQ-023 begin_transaction is ignored outside IDLE; deasserting it SHALL NOT alter state.
REQ-024 In SELECTED, a handshake SHALL load tx_data into the shift register and move state to SHIFT.
REQ-025 In SHIFT, sck SHALL toggle every cycle, giving 8 sck periods (16 cycles).
REQ-026 In SHIFT, mosi SHALL be valid before each sck rise, and miso SHALL be sampled on each sck rise.
REQ-027 On the 8th sck fall, the byte SHALL complete: rx_valid pulses, sck=0 and state returns to SELECTED.
REQ-028 An end_transaction pulse in SELECTED SHALL move state to IDLE with cs=1 on the next edge.
REQ-029 An end_transaction pulse in DELAY SHALL abort to IDLE with cs=1.
REQ-030 An end_transaction pulse in SHIFT SHALL be latched; the current byte completes, then state goes to IDLE.
REQ-031 end_transaction in IDLE is ignored; a simultaneous begin_transaction in IDLE is honoured.
REQ-032 cs SHALL be 0 in DELAY, SELECTED and SHIFT, and 1 in IDLE.
REQ-033 sck SHALL be 0 outside SHIFT.

Reset
REQ-034 While rst_n=0, the block SHALL hold state=IDLE, cs=1, sck=0, mosi=0, delay_count=0, delay_finished=0, rx_data=0, rx_valid=0 and tx_ready=0.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no partial rx_valid.

Configuration
REQ-036 With SPI_LOOPBACK_EN defined, the shifter SHALL sample mosi instead of miso, and miso SHALL be ignored.
REQ-037 Without SPI_LOOPBACK_EN, miso SHALL be used.

Structure
REQ-038 Package spi_pkg SHALL hold the state enum and the DEFAULT_DELAY_CYCLES=200 constant.
REQ-039 Sub-module spi_shifter SHALL hold the 8-bit shift register, the bit counter and sck generation; the FSM, delay counter and cs SHALL stay in spi.

Verification
REQ-040 Idle: begin_transaction=0 for 10 cycles after reset -> cs=1, state=0.
REQ-041 Start: begin_transaction=1, check at +50 cycles -> cs=0, state=1, delay_finished=0; at +100 -> delay_finished=0; at +350 -> delay_finished=1.
REQ-042 Release: begin_transaction=0 after the delay, wait 250 cycles -> state=2, cs=0, sck=0.
REQ-043 Byte: tx_data=0x74 handshake in SELECTED, miso driven with 0xA5 -> mosi shows 0,1,1,1,0,1,0,0 on the sck rises; after 16 cycles rx_valid pulses with rx_data=0xA5 and state=2.
REQ-044 Close/abort: end_transaction during SHIFT -> byte completes, then state=0, cs=1; end_transaction at +20 cycles of DELAY -> state=0, cs=1, delay_finished=0.
REQ-045 Reset: rst_n=0 at bit 4 of a byte -> cs=1, sck=0 and state=0 immediately, with no rx_valid.
